// File: rtl/uart_rx.sv
// UART receiver: 16x oversampled, LSB-first, one done pulse per frame.
// Optional even-parity stage enabled by defining UART_RX_PARITY_EN.
module uart_rx #(
  parameter int D_BIT   = 8,
  parameter int SB_TICK = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             tick_in,
  input  logic             rx_in,
  output logic [D_BIT-1:0] dato_out,
  output logic             rx_done_tick,
  output logic             frame_err,
  output logic             parity_err
);

  // s must also reach SB_TICK-1 when two stop bits are configured
  localparam int SW = (SB_TICK > 16) ? $clog2(SB_TICK) : 4;

`ifdef UART_RX_PARITY_EN
  typedef enum logic [4:0] {
    IDLE   = 5'b00001,
    START  = 5'b00010,
    DATA   = 5'b00100,
    PARITY = 5'b01000,
    STOP   = 5'b10000
  } state_t;
`else
  typedef enum logic [4:0] {
    IDLE   = 5'b00001,
    START  = 5'b00010,
    DATA   = 5'b00100,
    STOP   = 5'b10000
  } state_t;
`endif

  state_t           state;
  logic [SW-1:0]    s;
  logic [2:0]       n;
  logic [D_BIT-1:0] shift;
  logic             rx_meta, rx_s, rx_q;
`ifdef UART_RX_PARITY_EN
  logic             par_err_q;
`else
  assign parity_err = 1'b0;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state        <= IDLE;
      s            <= '0;
      n            <= '0;
      shift        <= '0;
      dato_out     <= '0;
      rx_done_tick <= 1'b0;
      frame_err    <= 1'b0;
      rx_meta      <= 1'b1;
      rx_s         <= 1'b1;
      rx_q         <= 1'b1;
`ifdef UART_RX_PARITY_EN
      parity_err   <= 1'b0;
      par_err_q    <= 1'b0;
`endif
    end else begin
      rx_meta      <= rx_in;
      rx_s         <= rx_meta;
      rx_q         <= rx_s;
      rx_done_tick <= 1'b0;
      case (state)
        // Falling edge rather than low level, so a held break is not re-framed
        IDLE: begin
          if (rx_q && !rx_s) begin
            state <= START;
            s     <= '0;
          end
        end
        START: begin
          if (tick_in) begin
            if (s == SW'(7)) begin
              if (!rx_s) begin
                state <= DATA;
                s     <= '0;
                n     <= '0;
              end else begin
                state <= IDLE;
              end
            end else begin
              s <= s + 1'b1;
            end
          end
        end
        DATA: begin
          if (tick_in) begin
            if (s == SW'(15)) begin
              s     <= '0;
              shift <= {rx_s, shift[D_BIT-1:1]};
              if (n == 3'(D_BIT - 1)) begin
`ifdef UART_RX_PARITY_EN
                state <= PARITY;
`else
                state <= STOP;
`endif
              end else begin
                n <= n + 1'b1;
              end
            end else begin
              s <= s + 1'b1;
            end
          end
        end
`ifdef UART_RX_PARITY_EN
        PARITY: begin
          if (tick_in) begin
            if (s == SW'(15)) begin
              s         <= '0;
              par_err_q <= (^shift) ^ rx_s;
              state     <= STOP;
            end else begin
              s <= s + 1'b1;
            end
          end
        end
`endif
        STOP: begin
          if (tick_in) begin
            if (s == SW'(SB_TICK - 1)) begin
              dato_out     <= shift;
              frame_err    <= ~rx_s;
              rx_done_tick <= 1'b1;
`ifdef UART_RX_PARITY_EN
              parity_err   <= par_err_q;
`endif
              state        <= IDLE;
            end else begin
              s <= s + 1'b1;
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_uart_rx.sv
// Self-checking bench for uart_rx: directed scenarios plus random frames
// compared against a frame-level reference built from the serial bit sequence.
module tb_uart_rx;

  localparam int D_BIT   = 8;
  localparam int SB_TICK = 16;

  logic             clk = 1'b0;
  logic             rst_n;
  logic             tick_in;
  logic             rx_in;
  logic [D_BIT-1:0] dato_out;
  logic             rx_done_tick;
  logic             frame_err;
  logic             parity_err;

  int tests = 0;
  int fails = 0;

  // {parity_err, frame_err, data}
  logic [D_BIT+1:0] got_q[$];
  logic [D_BIT+1:0] exp_q[$];

  uart_rx #(.D_BIT(D_BIT), .SB_TICK(SB_TICK)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .tick_in      (tick_in),
    .rx_in        (rx_in),
    .dato_out     (dato_out),
    .rx_done_tick (rx_done_tick),
    .frame_err    (frame_err),
    .parity_err   (parity_err)
  );

  always #5 clk = ~clk;

  always @(negedge clk)
    if (rst_n === 1'b1 && rx_done_tick === 1'b1)
      got_q.push_back({parity_err, frame_err, dato_out});

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp)
    else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // One tick pulse every 4 clocks; all drives happen 1ns after a posedge
  task automatic do_tick();
    tick_in = 1'b1;
    @(posedge clk); #1;
    tick_in = 1'b0;
    repeat (3) @(posedge clk);
    #1;
  endtask

  task automatic send_bit(input logic b, input int nt);
    rx_in = b;
    repeat (nt) do_tick();
  endtask

  task automatic send_frame(input logic [D_BIT-1:0] data, input logic stop_b,
                            input logic pbit);
    send_bit(1'b0, 16);
    for (int i = 0; i < D_BIT; i++) send_bit(data[i], 16);
`ifdef UART_RX_PARITY_EN
    send_bit(pbit, 16);
    exp_q.push_back({(^data) ^ pbit, ~stop_b, data});
`else
    exp_q.push_back({1'b0, ~stop_b, data});
`endif
    send_bit(stop_b, SB_TICK);
  endtask

  task automatic check_frames(input string tag);
    logic [D_BIT+1:0] g, e;
    chk({tag, "_count"}, got_q.size(), exp_q.size());
    while (got_q.size() > 0 && exp_q.size() > 0) begin
      g = got_q.pop_front();
      e = exp_q.pop_front();
      chk({tag, "_data"}, g[D_BIT-1:0], e[D_BIT-1:0]);
      chk({tag, "_ferr"}, g[D_BIT], e[D_BIT]);
      chk({tag, "_perr"}, g[D_BIT+1], e[D_BIT+1]);
    end
    got_q.delete();
    exp_q.delete();
  endtask

  initial begin
    logic [D_BIT-1:0] rd;
    logic             rstop;
    int               gap;

    rst_n = 1'b0; tick_in = 1'b0; rx_in = 1'b1;
    repeat (5) @(posedge clk);
    @(negedge clk);
    chk("rst_dato", dato_out, '0);
    chk("rst_done", rx_done_tick, 1'b0);
    chk("rst_ferr", frame_err, 1'b0);
    chk("rst_perr", parity_err, 1'b0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    repeat (4) do_tick();

    // Clean 0xA5
    send_frame(8'hA5, 1'b1, 1'b0);
    send_bit(1'b1, 32);
    check_frames("a5");

    // Short low glitch aborts in START
    send_bit(1'b0, 4);
    send_bit(1'b1, 32);
    check_frames("glitch");
    chk("glitch_hold", dato_out, 8'hA5);

    // Stop bit low
    send_frame(8'h3C, 1'b0, 1'b0);
    send_bit(1'b1, 32);
    check_frames("ferr");

    // Back-to-back frames
    send_frame(8'h00, 1'b1, 1'b0);
    send_frame(8'hFF, 1'b1, 1'b1);
    send_bit(1'b1, 32);
    check_frames("b2b");
    chk("b2b_last", dato_out, 8'hFF);

    // Reset after four data bits discards the partial frame
    send_bit(1'b0, 16);
    for (int i = 0; i < 4; i++) send_bit(1'(8'h5A >> i), 16);
    rst_n = 1'b0; rx_in = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    chk("midrst_dato", dato_out, '0);
    chk("midrst_done", rx_done_tick, 1'b0);
    rst_n = 1'b1;
    send_bit(1'b1, 32);
    chk("midrst_none", got_q.size(), 0);
    send_frame(8'h5A, 1'b1, 1'b0);
    send_bit(1'b1, 32);
    check_frames("after_rst");

    // Break: line held low well past the frame yields exactly one errored frame
    send_frame(8'h00, 1'b0, 1'b0);
    send_bit(1'b0, 64);
    send_bit(1'b1, 32);
    check_frames("break");
    send_frame(8'h81, 1'b1, 1'b0);
    send_bit(1'b1, 32);
    check_frames("post_break");

    // Parity bit cases (expected parity_err is 0 in the default build)
    send_frame(8'h07, 1'b1, 1'b1);
    send_bit(1'b1, 24);
    send_frame(8'h07, 1'b1, 1'b0);
    send_bit(1'b1, 24);
    check_frames("parity");

    // Random frames, random stop bits and gaps
    for (int k = 0; k < 12; k++) begin
      rd    = D_BIT'($urandom);
      rstop = ($urandom_range(0, 3) != 0);
      gap   = $urandom_range(0, 24);
      // A low stop bit needs a high interval before the next start edge
      if (!rstop && gap < 8) gap = 8;
      send_frame(rd, rstop, 1'($urandom));
      if (gap > 0) send_bit(1'b1, gap);
    end
    send_bit(1'b1, 32);
    check_frames("rand");

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
